axis_toplevel_mux: RTL and testbench

//  Packet-level AXI-Stream dispatcher: NUM_RX_LANES input streams, each buffered in a FIFO, are

---
 rtl/axis_mux_pkg.sv | 21 ++
 rtl/axis_lane_fifo.sv | 48 ++++
 rtl/axis_toplevel_mux.sv | 130 +++++++++++++
 tb/tb_axis_toplevel_mux.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mux_pkg.sv
// Shared widths, beat layout and lane-index helpers for the packet-level AXI-Stream dispatcher.
package axis_mux_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;
  localparam int AXIS_NUM_LANES  = 2;

  // Index width for a lane count; a single lane still needs one bit to name it.
  function automatic int lane_idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  localparam int AXIS_LANE_IDX_W = lane_idx_width(AXIS_NUM_LANES);

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic [AXIS_KEEP_WIDTH-1:0] keep;
    logic                       last;
  } axis_beat_t;

endpackage

// File: rtl/axis_lane_fifo.sv
// First-word-fall-through beat buffer for one RX lane; writes while full are silently dropped
// unless a read frees the slot on the same edge.
module axis_lane_fifo
  import axis_mux_pkg::*;
#(
  parameter int WIDTH = $bits(axis_beat_t),
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  // The extra pointer bit separates full from empty when the address bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axis_toplevel_mux.sv
// Packet dispatcher: buffers each RX lane and locks every TX lane to one RX lane for a whole
// packet, allocating idle TX lanes round-robin in ascending lane order.
module axis_toplevel_mux
  import axis_mux_pkg::*;
#(
  parameter int NUM_RX_LANES = 2,
  parameter int NUM_TX_LANES = 2,
  parameter int DATA_WIDTH   = AXIS_DATA_WIDTH,
  parameter int KEEP_WIDTH   = AXIS_KEEP_WIDTH,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_axis_tvalid [NUM_RX_LANES-1:0],
  input  logic [DATA_WIDTH-1:0] rx_axis_tdata  [NUM_RX_LANES-1:0],
  input  logic                  rx_axis_tlast  [NUM_RX_LANES-1:0],
  input  logic [KEEP_WIDTH-1:0] rx_axis_tkeep  [NUM_RX_LANES-1:0],
  input  logic                  tx_axis_tready [NUM_TX_LANES-1:0],
  output logic                  tx_axis_tvalid [NUM_TX_LANES-1:0],
  output logic [DATA_WIDTH-1:0] tx_axis_tdata  [NUM_TX_LANES-1:0],
  output logic                  tx_axis_tlast  [NUM_TX_LANES-1:0],
  output logic [KEEP_WIDTH-1:0] tx_axis_tkeep  [NUM_TX_LANES-1:0]
);

  localparam int RXW    = lane_idx_width(NUM_RX_LANES);
  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [BEAT_W-1:0]       head [NUM_RX_LANES];
  logic [NUM_RX_LANES-1:0] fifo_empty;
  logic [NUM_RX_LANES-1:0] fifo_pop;

  logic [NUM_TX_LANES-1:0] busy, busy_nxt;
  logic [NUM_TX_LANES-1:0] cool, cool_nxt;
  logic [RXW-1:0]          grant_idx     [NUM_TX_LANES];
  logic [RXW-1:0]          grant_idx_nxt [NUM_TX_LANES];
  logic [RXW-1:0]          rr_ptr        [NUM_TX_LANES];
  logic [RXW-1:0]          rr_ptr_nxt    [NUM_TX_LANES];

  for (genvar i = 0; i < NUM_RX_LANES; i++) begin : g_rx
    axis_lane_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (rx_axis_tvalid[i]),
      .wr_data ({rx_axis_tdata[i], rx_axis_tkeep[i], rx_axis_tlast[i]}),
      .rd_en   (fifo_pop[i]),
      .rd_data (head[i]),
      .empty   (fifo_empty[i])
    );
  end

  // A granted lane shows its FIFO head; anything else drives zeros.
  always_comb begin
    for (int j = 0; j < NUM_TX_LANES; j++) begin
      tx_axis_tvalid[j] = 1'b0;
      tx_axis_tdata[j]  = '0;
      tx_axis_tkeep[j]  = '0;
      tx_axis_tlast[j]  = 1'b0;
      if (busy[j] && !fifo_empty[grant_idx[j]]) begin
        tx_axis_tvalid[j] = 1'b1;
        {tx_axis_tdata[j], tx_axis_tkeep[j], tx_axis_tlast[j]} = head[grant_idx[j]];
      end
    end
  end

  always_comb begin
    fifo_pop = '0;
    for (int j = 0; j < NUM_TX_LANES; j++) begin
      if (tx_axis_tvalid[j] && tx_axis_tready[j]) fifo_pop[grant_idx[j]] = 1'b1;
    end
  end

  // Release on tlast handshake, then sit out one cycle so a waiting peer gets the next packet.
  // Idle lanes claim ungranted non-empty FIFOs in ascending TX order, each from its own pointer.
  always_comb begin
    logic [NUM_RX_LANES-1:0] avail;
    logic [RXW-1:0]          cand;
    logic                    found;

    avail         = ~fifo_empty;
    busy_nxt      = busy;
    cool_nxt      = '0;
    grant_idx_nxt = grant_idx;
    rr_ptr_nxt    = rr_ptr;
    cand          = '0;
    found         = 1'b0;

    for (int j = 0; j < NUM_TX_LANES; j++) begin
      if (busy[j]) avail[grant_idx[j]] = 1'b0;
    end

    for (int j = 0; j < NUM_TX_LANES; j++) begin
      if (busy[j]) begin
        if (tx_axis_tvalid[j] && tx_axis_tready[j] && tx_axis_tlast[j]) begin
          busy_nxt[j] = 1'b0;
          cool_nxt[j] = 1'b1;
        end
      end else if (!cool[j]) begin
        found = 1'b0;
        for (int k = 0; k < NUM_RX_LANES; k++) begin
          cand = RXW'((int'(rr_ptr[j]) + k) % NUM_RX_LANES);
          if (!found && avail[cand]) begin
            found            = 1'b1;
            busy_nxt[j]      = 1'b1;
            grant_idx_nxt[j] = cand;
            rr_ptr_nxt[j]    = RXW'((int'(cand) + 1) % NUM_RX_LANES);
            avail[cand]      = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      cool      <= '0;
      grant_idx <= '{default: '0};
      rr_ptr    <= '{default: '0};
    end else begin
      busy      <= busy_nxt;
      cool      <= cool_nxt;
      grant_idx <= grant_idx_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_axis_toplevel_mux.sv
// Scoreboard bench for axis_toplevel_mux: expected beats are queued per TX lane as they are
// driven and matched against every output handshake.
module tb_axis_toplevel_mux;

  localparam int NRX   = 2;
  localparam int NTX   = 2;
  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int DEPTH = 16;
  localparam int BW    = DW + KW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_tvalid [NRX-1:0];
  logic [DW-1:0] rx_tdata  [NRX-1:0];
  logic          rx_tlast  [NRX-1:0];
  logic [KW-1:0] rx_tkeep  [NRX-1:0];
  logic          tx_tready [NTX-1:0];
  logic          tx_tvalid [NTX-1:0];
  logic [DW-1:0] tx_tdata  [NTX-1:0];
  logic          tx_tlast  [NTX-1:0];
  logic [KW-1:0] tx_tkeep  [NTX-1:0];

  logic [BW-1:0] exp_q [NTX][$];
  logic          prev_stall [NTX];
  logic [BW-1:0] prev_beat  [NTX];
  int            n_vectors = 0;
  int            n_miscompares = 0;

  axis_toplevel_mux #(
    .NUM_RX_LANES (NRX),
    .NUM_TX_LANES (NTX),
    .DATA_WIDTH   (DW),
    .KEEP_WIDTH   (KW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_axis_tvalid (rx_tvalid),
    .rx_axis_tdata  (rx_tdata),
    .rx_axis_tlast  (rx_tlast),
    .rx_axis_tkeep  (rx_tkeep),
    .tx_axis_tready (tx_tready),
    .tx_axis_tvalid (tx_tvalid),
    .tx_axis_tdata  (tx_tdata),
    .tx_axis_tlast  (tx_tlast),
    .tx_axis_tkeep  (tx_tkeep)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clear_rx();
    for (int i = 0; i < NRX; i++) begin
      rx_tvalid[i] = 1'b0;
      rx_tdata[i]  = '0;
      rx_tlast[i]  = 1'b0;
      rx_tkeep[i]  = '0;
    end
  endtask

  task automatic apply_stimulus(input int lane, input logic [DW-1:0] data, input logic [KW-1:0] keep,
                                input logic last, input int tx_exp);
    rx_tvalid[lane] = 1'b1;
    rx_tdata[lane]  = data;
    rx_tkeep[lane]  = keep;
    rx_tlast[lane]  = last;
    if (tx_exp >= 0) exp_q[tx_exp].push_back({data, keep, last});
  endtask

  task automatic wait_drain(input int budget, input bit toggle0);
    int n;
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < budget) begin
      if (toggle0) tx_tready[0] = ~tx_tready[0];
      @(posedge clk); #1;
      n++;
    end
    check_output("drain_pending", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Output monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [BW-1:0] beat;
    for (int j = 0; j < NTX; j++) begin
      beat = {tx_tdata[j], tx_tkeep[j], tx_tlast[j]};
      if (!rst_n) begin
        prev_stall[j] = 1'b0;
      end else begin
        if (prev_stall[j])
          check_output($sformatf("tx%0d_hold", j), 64'({tx_tvalid[j], beat}), 64'({1'b1, prev_beat[j]}));
        if (tx_tvalid[j] && tx_tready[j]) begin
          if (exp_q[j].size() == 0)
            check_output($sformatf("tx%0d_unexpected_beat", j), 64'({1'b1, beat}), 64'd0);
          else
            check_output($sformatf("tx%0d_beat", j), 64'(beat), 64'(exp_q[j].pop_front()));
        end
        if (!tx_tvalid[j])
          check_output($sformatf("tx%0d_idle_zero", j), 64'(beat), 64'd0);
        prev_stall[j] = tx_tvalid[j] && !tx_tready[j];
        prev_beat[j]  = beat;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    clear_rx();
    for (int j = 0; j < NTX; j++) begin
      tx_tready[j]  = 1'b1;
      prev_stall[j] = 1'b0;
      prev_beat[j]  = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < NTX; j++) begin
      check_output($sformatf("rst_tvalid%0d", j), 64'(tx_tvalid[j]), 64'd0);
      check_output($sformatf("rst_beat%0d", j), 64'({tx_tdata[j], tx_tkeep[j], tx_tlast[j]}), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identical 6-beat packets on both RX lanes; tvalid appears two edges after the first write
    for (int b = 0; b < 6; b++) begin
      logic [DW-1:0] d;
      d = {8'(4*b), 8'(4*b+1), 8'(4*b+2), 8'(4*b+3)};
      apply_stimulus(0, d, 4'h2, b == 5, 0);
      apply_stimulus(1, d, 4'h2, b == 5, 1);
      @(posedge clk); #1;
      if (b == 0) check_output("lat_after_write_edge", 64'({tx_tvalid[1], tx_tvalid[0]}), 64'd0);
      if (b == 1) check_output("lat_after_grant_edge", 64'({tx_tvalid[1], tx_tvalid[0]}), 64'b11);
    end
    clear_rx();
    wait_drain(60, 1'b0);

    // Only rx1 active: the lowest idle TX lane takes it
    for (int b = 0; b < 3; b++) begin
      apply_stimulus(1, 32'hA000_0000 + DW'(b), 4'hF, b == 2, 0);
      @(posedge clk); #1;
    end
    clear_rx();
    wait_drain(60, 1'b0);

    // Backpressure toggling on tx0
    for (int b = 0; b < 6; b++) begin
      apply_stimulus(0, 32'hB000_0000 + DW'(b), 4'h5, b == 5, 0);
      tx_tready[0] = ~tx_tready[0];
      @(posedge clk); #1;
    end
    clear_rx();
    wait_drain(80, 1'b1);
    tx_tready[0] = 1'b1;

    // Two queued packets on rx0: first to tx0, second to tx1
    tx_tready[0] = 1'b0;
    for (int b = 0; b < 6; b++) begin
      apply_stimulus(0, 32'hD000_0000 + DW'(b), 4'h9, (b == 2) || (b == 5), (b < 3) ? 0 : 1);
      @(posedge clk); #1;
    end
    clear_rx();
    repeat (3) @(posedge clk);
    #1;
    tx_tready[0] = 1'b1;
    wait_drain(80, 1'b0);

    // Overflow: only the first DEPTH beats survive
    tx_tready[0] = 1'b0;
    tx_tready[1] = 1'b0;
    for (int b = 0; b < DEPTH + 2; b++) begin
      apply_stimulus(0, 32'hC000_0000 + DW'(b), 4'h2, b >= DEPTH - 1, (b < DEPTH) ? 0 : -1);
      @(posedge clk); #1;
    end
    clear_rx();
    repeat (2) @(posedge clk);
    #1;
    tx_tready[0] = 1'b1;
    tx_tready[1] = 1'b1;
    wait_drain(100, 1'b0);

    // Reset in the middle of a packet drops it
    tx_tready[0] = 1'b0;
    tx_tready[1] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      apply_stimulus(0, 32'hE000_0000 + DW'(b), 4'h3, 1'b0, -1);
      @(posedge clk); #1;
    end
    clear_rx();
    @(posedge clk); #1;
    check_output("midpkt_valid_before_reset", 64'(tx_tvalid[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check_output("midpkt_reset_tvalid", 64'({tx_tvalid[1], tx_tvalid[0]}), 64'd0);
    check_output("midpkt_reset_beat0", 64'({tx_tdata[0], tx_tkeep[0], tx_tlast[0]}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tx_tready[0] = 1'b1;
    tx_tready[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output("after_reset_flushed", 64'({tx_tvalid[1], tx_tvalid[0]}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
